// File: rtl/vetores_pkg.sv
// ---------------------------------------------------------------------------
// vetores_pkg
// Shared definitions for the vector-stream source (sequenciador_vetores)
// and its operand table (tabela_vetores).
//   estado_t     : FSM states of the sequencer (IDLE, RUN, DONE)
//   W_PADRAO     : default operand width
//   DEPTH_PADRAO : default number of table entries
//   pack_vet     : packs an {a,b} pair at the default width into a table word
// ---------------------------------------------------------------------------
package vetores_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } estado_t;

    localparam int unsigned W_PADRAO     = 3;
    localparam int unsigned DEPTH_PADRAO = 4;

    // Table word layout: a in the upper half, b in the lower half.
    function automatic logic [2*W_PADRAO-1:0] pack_vet(
        input logic [W_PADRAO-1:0] a,
        input logic [W_PADRAO-1:0] b
    );
        return {a, b};
    endfunction

endpackage

// File: rtl/sequenciador_vetores_tabela.sv
// ---------------------------------------------------------------------------
// tabela_vetores
// DEPTH x 2W register file holding packed {a,b} operand pairs.
// Synchronous write, asynchronous (combinational) read, no reset: contents
// survive a reset of the surrounding sequencer.
//   clk     : system clock, rising edge
//   wr_en   : write strobe (already qualified by the caller)
//   wr_addr : write address
//   wr_data : packed entry {a,b}
//   rd_addr : read address
//   rd_data : entry at rd_addr
// ---------------------------------------------------------------------------
module tabela_vetores
    import vetores_pkg::*;
#(
    parameter int unsigned W     = W_PADRAO,
    parameter int unsigned DEPTH = DEPTH_PADRAO,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [2*W-1:0]  wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [2*W-1:0]  rd_data
);

    logic [2*W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sequenciador_vetores.sv
// ---------------------------------------------------------------------------
// sequenciador_vetores
// Synthesizable operand source for the vector-operations stage. A small
// table of {a,b} pairs is loaded through a write port; on start the block
// streams min(num_vet, DEPTH) pairs, beginning at entry 0, over a
// valid/ready handshake, then pulses done for one cycle.
//   clk, rst_n : system clock (rising edge), asynchronous active-low reset
//   wr_en      : table write strobe (honoured only outside RUN)
//   wr_addr    : table write address
//   wr_data    : packed entry, [2W-1:W] = a, [W-1:0] = b
//   start      : begin streaming (sampled only in IDLE)
//   num_vet    : number of entries to stream
//   a, b       : registered operand pair to the consumer
//   valid      : a/b hold a pair
//   ready      : consumer accepts the pair when valid && ready
//   busy       : high while streaming
//   done       : one-cycle pulse after the last pair is accepted
// ---------------------------------------------------------------------------
module sequenciador_vetores
    import vetores_pkg::*;
#(
    parameter int unsigned W     = W_PADRAO,
    parameter int unsigned DEPTH = DEPTH_PADRAO,
    // Derived widths; not meant to be overridden.
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [2*W-1:0]  wr_data,
    input  logic            start,
    input  logic [CW-1:0]   num_vet,
    output logic [W-1:0]    a,
    output logic [W-1:0]    b,
    output logic            valid,
    input  logic            ready,
    output logic            busy,
    output logic            done
);

    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);
    localparam logic [CW-1:0] UM_CW    = CW'(1);
    localparam logic [AW-1:0] UM_AW    = AW'(1);

    estado_t         estado, prox_estado;
    logic [AW-1:0]   indice, prox_indice;
    logic [CW-1:0]   cnt,    prox_cnt;
    logic [W-1:0]    prox_a, prox_b;
    logic            prox_valid;

    logic            tab_wr_en;
    logic [AW-1:0]   rd_addr;
    logic [2*W-1:0]  rd_dado;
    logic [CW-1:0]   cnt_inicial;

    // Writes are blocked while streaming so a running stream never sees
    // its source data change.
    assign tab_wr_en = wr_en && (estado != RUN);

    // Entry 0 is fetched on the start edge; afterwards the running index
    // points at the next entry to present.
    assign rd_addr = (estado == RUN) ? indice : '0;

    // Clamp so the stream never revisits entries through index wrap.
    assign cnt_inicial = (num_vet > DEPTH_CW) ? DEPTH_CW : num_vet;

    tabela_vetores #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tabela (
        .clk     (clk),
        .wr_en   (tab_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_dado)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
            indice <= '0;
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            valid  <= 1'b0;
        end else begin
            estado <= prox_estado;
            indice <= prox_indice;
            cnt    <= prox_cnt;
            a      <= prox_a;
            b      <= prox_b;
            valid  <= prox_valid;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        prox_estado = estado;
        prox_indice = indice;
        prox_cnt    = cnt;
        prox_a      = a;
        prox_b      = b;
        prox_valid  = valid;

        case (estado)
            IDLE: begin
                if (start) begin
                    if (num_vet == '0) begin
                        prox_estado = DONE;
                    end else begin
                        prox_estado = RUN;
                        prox_cnt    = cnt_inicial;
                        prox_a      = rd_dado[2*W-1:W];
                        prox_b      = rd_dado[W-1:0];
                        prox_valid  = 1'b1;
                        prox_indice = UM_AW;
                    end
                end
            end

            RUN: begin
                // Without a handshake everything holds, keeping a/b stable.
                if (valid && ready) begin
                    prox_cnt = cnt - UM_CW;
                    if (cnt > UM_CW) begin
                        prox_a      = rd_dado[2*W-1:W];
                        prox_b      = rd_dado[W-1:0];
                        prox_indice = indice + UM_AW;
                    end else begin
                        prox_valid  = 1'b0;
                        prox_estado = DONE;
                    end
                end
            end

            DONE: begin
                prox_estado = IDLE;
            end

            default: begin
                prox_estado = IDLE;
                prox_valid  = 1'b0;
            end
        endcase
    end

    assign busy = (estado == RUN);
    assign done = (estado == DONE);

endmodule

// File: tb/tb_sequenciador_vetores.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_vetores
// Directed bench for sequenciador_vetores. A transaction-level model keeps a
// copy of the table and a queue of pairs still owed to the consumer; every
// cycle the DUT outputs are compared with it. Hand-computed literals pin the
// model at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_sequenciador_vetores;
    import vetores_pkg::*;

    localparam int unsigned W     = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned CW    = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [2*W-1:0]  wr_data = '0;
    logic            start = 1'b0;
    logic [CW-1:0]   num_vet = '0;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            valid;
    logic            ready = 1'b0;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    sequenciador_vetores #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .num_vet (num_vet),
        .a       (a),
        .b       (b),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2*W-1:0] tbl [DEPTH];
    logic [2*W-1:0] exp_q [$];     // pairs still owed to the consumer
    logic           m_done = 1'b0; // done expected in the current cycle
    logic [2*W-1:0] acc_q [$];     // pairs actually handed over by the DUT

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_done = 1'b0;
        end else begin
            logic done_prev;
            int unsigned n;
            done_prev = m_done;
            m_done = 1'b0;
            if (exp_q.size() > 0) begin
                // Streaming: start and writes are ignored.
                if (ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_done = 1'b1;
                end
            end else if (done_prev) begin
                if (wr_en) tbl[wr_addr] = wr_data;
            end else begin
                if (start) begin
                    n = (num_vet > DEPTH) ? DEPTH : int'(num_vet);
                    if (n == 0) m_done = 1'b1;
                    for (int unsigned i = 0; i < n; i++) exp_q.push_back(tbl[i]);
                end
                if (wr_en) tbl[wr_addr] = wr_data;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (exp_q.size() > 0);
        chk("valid", valid, exp_v);
        chk("busy", busy, exp_v);
        chk("done", done, m_done);
        if (!rst_n) begin
            chk("reset_a", a, 0);
            chk("reset_b", b, 0);
        end else if (exp_v) begin
            chk("a", a, exp_q[0][2*W-1:W]);
            chk("b", b, exp_q[0][W-1:0]);
        end
        if (rst_n && valid && ready) acc_q.push_back({a, b});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic escreve(input logic [AW-1:0] ad, input logic [2*W-1:0] d);
        wr_en = 1'b1; wr_addr = ad; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic dispara(input logic [CW-1:0] n);
        start = 1'b1; num_vet = n;
        tick();
        start = 1'b0;
    endtask

    task automatic aguarda_done(input int budget, input string nome);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk(nome, done, 1);
    endtask

    task automatic carrega_original();
        escreve(2'd0, pack_vet(3'b101, 3'b011));
        escreve(2'd1, pack_vet(3'b000, 3'b000));
        escreve(2'd2, pack_vet(3'b111, 3'b000));
        escreve(2'd3, pack_vet(3'b010, 3'b101));
    endtask

    task automatic chk_original(input string nome);
        chk({nome, "_count"}, acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            chk({nome, "_p0"}, acc_q[0], 6'b101011);
            chk({nome, "_p1"}, acc_q[1], 6'b000000);
            chk({nome, "_p2"}, acc_q[2], 6'b111000);
            chk({nome, "_p3"}, acc_q[3], 6'b010101);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #1;
        chk("lit_reset_valid", valid, 0);
        chk("lit_reset_a", a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: four pairs back to back with ready held high
        carrega_original();
        ready = 1'b1;
        dispara(3'd4);
        chk("t1_v0", valid, 1);
        chk("t1_ab0", {a, b}, 6'b101011);
        tick(); chk("t1_ab1", {a, b}, 6'b000000);
        tick(); chk("t1_ab2", {a, b}, 6'b111000);
        tick(); chk("t1_ab3", {a, b}, 6'b010101);
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_valid", valid, 0);
        tick();
        chk("t1_done_low", done, 0);

        // 2: ready toggling 1,0,0,1,1,0,1
        acc_q.delete();
        dispara(3'd4);
        for (int k = 0; k < 7; k++) begin
            ready = pat[k];
            tick();
            if (k < 6) chk("t2_no_early_done", done, 0);
        end
        chk("t2_done", done, 1);
        chk_original("t2");
        ready = 1'b1;
        tick();

        // 3: num_vet = 0, then num_vet = 7 clamped to DEPTH
        dispara(3'd0);
        chk("t3_zero_done", done, 1);
        chk("t3_zero_valid", valid, 0);
        tick();
        chk("t3_zero_done_low", done, 0);
        acc_q.delete();
        dispara(3'd7);
        aguarda_done(20, "t3_clamp_done");
        tick();
        chk_original("t3");

        // 4: write and restart during RUN are ignored
        acc_q.delete();
        dispara(3'd4);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 6'b111111;
        start = 1'b1; num_vet = 3'd1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        aguarda_done(20, "t4_done");
        tick();
        chk_original("t4");
        escreve(2'd2, 6'b111111);
        acc_q.delete();
        dispara(3'd4);
        aguarda_done(20, "t4b_done");
        tick();
        chk("t4b_count", acc_q.size(), 4);
        if (acc_q.size() == 4) chk("t4b_p2", acc_q[2], 6'b111111);

        // 5: asynchronous reset after the second handshake
        escreve(2'd2, pack_vet(3'b111, 3'b000));
        acc_q.delete();
        dispara(3'd4);
        tick();
        tick();
        chk("t5_pre_ab", {a, b}, 6'b111000);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_a", a, 0);
        chk("t5_rst_b", b, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        acc_q.delete();
        dispara(3'd4);
        aguarda_done(20, "t5_done");
        tick();
        chk_original("t5");

        // 6: start in DONE ignored, start in the following IDLE accepted
        acc_q.delete();
        dispara(3'd2);
        aguarda_done(20, "t6_done");
        start = 1'b1; num_vet = 3'd4;
        tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_valid", valid, 0);
        tick();
        start = 1'b0;
        chk("t6_run_valid", valid, 1);
        chk("t6_run_ab", {a, b}, 6'b101011);
        aguarda_done(20, "t6b_done");
        tick();
        chk("t6_total", acc_q.size(), 6);
        if (acc_q.size() == 6) begin
            chk("t6_p1", acc_q[1], 6'b000000);
            chk("t6_p5", acc_q[5], 6'b010101);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
